// File: rtl/ula_mc.sv
// ula_mc: registered ALU with a post-ALU shifter and a valid/ready handshake.
// Each accepted operation is held in the output register until the consumer
// takes it. The optional iterative unsigned multiply (select[7:6] = 11) is
// built only when the macro ULA_MC_MUL_EN is defined. Without the macro that
// select code returns a zero result with Z set.
module ula_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [7:0]       select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             N,
  output logic             Z,
  output logic             C,
  output logic             busy
);

  // Control word fields
  logic       sll8, sra1, ena, enb, inva, inc;
  logic [1:0] f_sel;

  assign sll8  = select[7];
  assign sra1  = select[6];
  assign f_sel = select[5:4];
  assign ena   = select[3];
  assign enb   = select[2];
  assign inva  = select[1];
  assign inc   = select[0];

`ifdef ULA_MC_MUL_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HOLD = 2'd1, S_MUL = 2'd2} state_t;
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HOLD = 2'd1} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             n_q, n_d, z_q, z_d, c_q, c_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

`ifdef ULA_MC_MUL_EN
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Combinational ALU and shifter for a single-cycle operation
  logic [WIDTH-1:0] op_a, op_b, alu_res, shift_res;
  logic [WIDTH:0]   sum_ext;
  logic             alu_n, alu_z, alu_c;

  // Gate operands, evaluate the ALU, then shift; flags come from the
  // pre-shift ALU value.
  always_comb begin
    op_a    = (ena ? A : '0) ^ {WIDTH{inva}};
    op_b    = enb ? B : '0;
    sum_ext = {1'b0, op_a} + {1'b0, op_b} + (WIDTH + 1)'(inc);
    alu_c   = 1'b0;
    case (f_sel)
      2'b00:   alu_res = op_a & op_b;
      2'b01:   alu_res = op_a | op_b;
      2'b10:   alu_res = ~op_b;
      default: begin
        alu_res = sum_ext[WIDTH-1:0];
        alu_c   = sum_ext[WIDTH];
      end
    endcase
    alu_n = alu_res[WIDTH-1];
    alu_z = (alu_res == '0);
    case ({sll8, sra1})
      2'b10:   shift_res = {alu_res[WIDTH-9:0], 8'h00};
      2'b01:   shift_res = {alu_res[WIDTH-1], alu_res[WIDTH-1:1]};
      2'b00:   shift_res = alu_res;
      default: begin
        // Multiply code: a zero result when the multiplier is not built;
        // when it is, this path is never loaded.
        shift_res = '0;
        alu_n     = 1'b0;
        alu_z     = 1'b1;
        alu_c     = 1'b0;
      end
    endcase
  end

  // Handshake: accept when idle, or when the held result retires this cycle
  assign in_ready = (state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready);

`ifdef ULA_MC_MUL_EN
  logic [WIDTH-1:0] acc_step;
  assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif

  // Next-state logic: retire, iterate the multiply, or load a new operation
  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    n_d         = n_q;
    z_d         = z_q;
    c_d         = c_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
`ifdef ULA_MC_MUL_EN
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
`endif

    case (state_q)
      S_HOLD: begin
        if (out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      end
`ifdef ULA_MC_MUL_EN
      S_MUL: begin
        acc_d    = acc_step;
        mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          state_d     = S_HOLD;
          out_d       = acc_step;
          n_d         = acc_step[WIDTH-1];
          z_d         = (acc_step == '0);
          c_d         = 1'b0;
          out_valid_d = 1'b1;
          busy_d      = 1'b0;
        end
      end
`endif
      default: ;
    endcase

    if (in_valid && in_ready) begin
`ifdef ULA_MC_MUL_EN
      if (sll8 && sra1) begin
        state_d     = S_MUL;
        busy_d      = 1'b1;
        out_valid_d = 1'b0;
        mcand_d     = A;
        mplier_d    = B;
        acc_d       = '0;
        cnt_d       = '0;
      end else begin
        state_d     = S_HOLD;
        out_valid_d = 1'b1;
        out_d       = shift_res;
        n_d         = alu_n;
        z_d         = alu_z;
        c_d         = alu_c;
      end
`else
      state_d     = S_HOLD;
      out_valid_d = 1'b1;
      out_d       = shift_res;
      n_d         = alu_n;
      z_d         = alu_z;
      c_d         = alu_c;
`endif
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      out_q       <= '0;
      n_q         <= 1'b0;
      z_q         <= 1'b1;
      c_q         <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef ULA_MC_MUL_EN
      mcand_q     <= '0;
      mplier_q    <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      n_q         <= n_d;
      z_q         <= z_d;
      c_q         <= c_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef ULA_MC_MUL_EN
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign out       = out_q;
  assign N         = n_q;
  assign Z         = z_q;
  assign C         = c_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_ula_mc.sv
// Self-checking bench for ula_mc (WIDTH=32): directed vector table, handshake
// corner sequences, randomized traffic against a behavioural model, and the
// multiply sequences when ULA_MC_MUL_EN is defined.
module tb_ula_mc;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  A, B;
  logic [7:0]    select;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out;
  logic          N, Z, C;
  logic          busy;

  ula_mc #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .select(select), .out_valid(out_valid),
    .out_ready(out_ready), .out(out), .N(N), .Z(Z), .C(C), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] o;
    logic        n;
    logic        z;
    logic        c;
  } res_t;

  // Behavioural reference: plain arithmetic on the documented rules
  function automatic res_t ref_model(input logic [31:0] a_in, input logic [31:0] b_in,
                                     input logic [7:0] s);
    longint unsigned mask = 64'hFFFF_FFFF;
    longint unsigned a, b, r, prod;
    res_t res;
    a = s[3] ? longint'(a_in) : 0;
    if (s[1]) a = a ^ mask;
    b = s[2] ? longint'(b_in) : 0;
    res.c = 1'b0;
    case ({s[5], s[4]})
      2'b00: r = a & b;
      2'b01: r = a | b;
      2'b10: r = (~b) & mask;
      default: begin
        r = a + b + longint'(s[0]);
        res.c = (r > mask);
        r = r & mask;
      end
    endcase
    res.n = r[31];
    res.z = (r == 0);
    if (s[7] && s[6]) begin
`ifdef ULA_MC_MUL_EN
      prod  = (longint'(a_in) * longint'(b_in)) & mask;
      res.o = prod[31:0];
      res.n = prod[31];
      res.z = (prod == 0);
      res.c = 1'b0;
`else
      prod  = 0;
      res.o = prod[31:0];
      res.n = 1'b0;
      res.z = 1'b1;
      res.c = 1'b0;
`endif
    end else if (s[7]) begin
      r = (r * 256) & mask;
      res.o = r[31:0];
    end else if (s[6]) begin
      r = (r / 2) | (r & 64'h8000_0000);
      res.o = r[31:0];
    end else begin
      res.o = r[31:0];
    end
    return res;
  endfunction

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  sel;
    logic [31:0] o;
    logic        n;
    logic        z;
    logic        c;
  } vec_t;

  vec_t vecs[12];
  int   n_vec;

  task automatic check_result(input string tag, input res_t e);
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_out"}, out, e.o);
    check({tag, "_N"}, N, e.n);
    check({tag, "_Z"}, Z, e.z);
    check({tag, "_C"}, C, e.c);
  endtask

  initial begin
    res_t e, e1, e2;
    logic holding;
    res_t held;
    logic acc;
    int   lat;

    vecs[0]  = '{32'd5,        32'd7,        8'h3D, 32'd13,       1'b0, 1'b0, 1'b0};
    vecs[1]  = '{32'hFFFFFFFF, 32'd1,        8'h3C, 32'h0,        1'b0, 1'b1, 1'b1};
    vecs[2]  = '{32'h1,        32'h1,        8'hBC, 32'h200,      1'b0, 1'b0, 1'b0};
    vecs[3]  = '{32'h0,        32'h80000000, 8'h54, 32'hC0000000, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{32'hF0F0F0F0, 32'hFF00FF00, 8'h0C, 32'hF000F000, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{32'h0000000F, 32'h000000F0, 8'h1C, 32'h000000FF, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{32'h12345678, 32'hFFFFFFFF, 8'h24, 32'h0,        1'b0, 1'b1, 1'b0};
    vecs[7]  = '{32'h1,        32'h5,        8'h3B, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{32'h9,        32'h2,        8'h36, 32'h1,        1'b0, 1'b0, 1'b1};
    vecs[9]  = '{32'h2,        32'h4,        8'h7C, 32'h3,        1'b0, 1'b0, 1'b0};
    vecs[10] = '{32'hFF000000, 32'h1,        8'hBC, 32'h100,      1'b1, 1'b0, 1'b0};
`ifdef ULA_MC_MUL_EN
    n_vec = 11;
`else
    vecs[11] = '{32'd1000,     32'd3000,     8'hC0, 32'h0,        1'b0, 1'b1, 1'b0};
    n_vec = 12;
`endif

    // Reset state
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    A = '0; B = '0; select = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out", out, 32'h0);
    check("rst_N", N, 1'b0);
    check("rst_Z", Z, 1'b1);
    check("rst_C", C, 1'b0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    reset = 1'b0;
    #1 check("rst_in_ready", in_ready, 1'b1);
    $display("reset: out=%0h Z=%0b in_ready=%0b", out, Z, in_ready);

    // Directed vectors, back to back with the consumer always ready
    @(negedge clk);
    for (int i = 0; i < n_vec; i++) begin
      in_valid = 1'b1; A = vecs[i].a; B = vecs[i].b; select = vecs[i].sel;
      #1 check($sformatf("vec%0d_in_ready", i), in_ready, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      e = '{vecs[i].o, vecs[i].n, vecs[i].z, vecs[i].c};
      check_result($sformatf("vec%0d", i), e);
      check($sformatf("vec%0d_busy", i), busy, 1'b0);
      $display("vec %0d: A=%0h B=%0h sel=%02h -> out=%0h N=%0b Z=%0b C=%0b",
               i, vecs[i].a, vecs[i].b, vecs[i].sel, out, N, Z, C);
    end
    @(negedge clk);
    #1 check("retire_to_idle", out_valid, 1'b0);

    // Stalled consumer: first accepted, later ones wait, taken on retire cycle
    @(negedge clk);
    e1 = ref_model(32'd100, 32'd23, 8'h3C);
    e2 = ref_model(32'hAAAA0000, 32'h0000FFFF, 8'h1C);
    in_valid = 1'b1; A = 32'd100; B = 32'd23; select = 8'h3C; out_ready = 1'b0;
    @(negedge clk);
    A = 32'hAAAA0000; B = 32'h0000FFFF; select = 8'h1C;
    #1 check("stall_in_ready0", in_ready, 1'b0);
    check_result("stall_first", e1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      A = $urandom; B = $urandom;
      #1 check("stall_in_ready", in_ready, 1'b0);
      check("stall_hold_out", out, e1.o);
      A = 32'hAAAA0000; B = 32'h0000FFFF;
    end
    out_ready = 1'b1;
    #1 check("stall_release_ready", in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 check_result("stall_second", e2);
    $display("stall: first=%0h second=%0h", e1.o, out);
    @(negedge clk);
    #1 check("stall_idle", out_valid, 1'b0);

    // Reset while holding a result discards it
    in_valid = 1'b1; A = 32'd3; B = 32'd4; select = 8'h3C; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; out_ready = 1'b1;
    #1 check("hold_rst_valid", out_valid, 1'b0);
    check("hold_rst_out", out, 32'h0);
    check("hold_rst_Z", Z, 1'b1);
    check("hold_rst_in_ready", in_ready, 1'b1);
    $display("hold reset: out_valid=%0b out=%0h", out_valid, out);

    // Randomized traffic with random backpressure
    holding = 1'b0; held = '0;
    for (int it = 0; it < 300; it++) begin
      @(negedge clk);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      A = $urandom; B = $urandom; select = 8'($urandom);
`ifdef ULA_MC_MUL_EN
      if (select[7:6] == 2'b11) select[7] = 1'b0;
`endif
      #1;
      check("rnd_in_ready", in_ready, !holding || out_ready);
      check("rnd_valid", out_valid, holding);
      if (holding) begin
        check("rnd_out", out, held.o);
        check("rnd_NZC", {N, Z, C}, {held.n, held.z, held.c});
      end
      acc = in_valid && (!holding || out_ready);
      if (holding && out_ready) holding = 1'b0;
      if (acc) begin
        holding = 1'b1;
        held = ref_model(A, B, select);
      end
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    $display("random: %0d comparisons so far", n_cmp);

`ifdef ULA_MC_MUL_EN
    // Multiply: WIDTH busy cycles, then the product held until taken
    in_valid = 1'b1; A = 32'd1000; B = 32'd3000; select = 8'hC0; out_ready = 1'b0;
    #1 check("mul_in_ready", in_ready, 1'b1);
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check($sformatf("mul_busy%0d", k), busy, 1'b1);
      check($sformatf("mul_noready%0d", k), in_ready, 1'b0);
      check($sformatf("mul_novalid%0d", k), out_valid, 1'b0);
    end
    @(negedge clk);
    #1 check_result("mul", '{32'd3000000, 1'b0, 1'b0, 1'b0});
    check("mul_busy_done", busy, 1'b0);
    $display("mul: 1000*3000 -> out=%0d", out);
    out_ready = 1'b1;
    @(negedge clk);

    // Repeat run aborted by reset in cycle 10
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1 check("mul_abort_in_ready", in_ready, 1'b1);
    check("mul_abort_out", out, 32'h0);
    check("mul_abort_busy", busy, 1'b0);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      #1 check("mul_abort_novalid", out_valid, 1'b0);
    end
    $display("mul abort: out_valid=%0b out=%0h", out_valid, out);

    // Random multiplies with a bounded wait for the result
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      in_valid = 1'b1; A = $urandom; B = $urandom; select = 8'hC0 | 8'($urandom_range(0, 63));
      e = ref_model(A, B, select);
      lat = 0;
      do begin
        @(negedge clk);
        in_valid = 1'b0;
        lat++;
        #1;
      end while (!out_valid && lat < 100);
      check("rmul_latency", lat, W + 1);
      check_result("rmul", e);
      $display("rmul %0d: out=%0h latency=%0d", r, out, lat);
    end
    @(negedge clk);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
